// File: rtl/fifo_write_scheduler_pkg.sv
// rtl/fifo_write_scheduler_pkg.sv - shared defaults and index helper for the FIFO write scheduler
package fifo_write_scheduler_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_THRESHOLD = 5;
  localparam int DEF_NUM_REQ   = 4;

  // Modular increment of a requester index without a divider.
  function automatic int wrap_index(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fifo_write_scheduler_arbiter.sv
// rtl/fifo_write_scheduler_arbiter.sv - combinational round-robin arbiter
module rr_arbiter
  import fifo_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Search upward from ptr with wrap-around; first eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = wrap_index(int'(ptr), off, NUM_REQ);
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_scheduler.sv
// rtl/fifo_write_scheduler.sv - shares one FIFO write port among NUM_REQ producers
module fifo_write_scheduler
  import fifo_write_scheduler_pkg::*;
#(
  parameter int                 WIDTH      = DEF_WIDTH,
  parameter int                 DEPTH      = DEF_DEPTH,
  parameter int                 THRESHOLD  = DEF_THRESHOLD,
  parameter int                 NUM_REQ    = DEF_NUM_REQ,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = NUM_REQ'(1),
  localparam int                CNT_W      = $clog2(DEPTH + 1),
  localparam int                IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_rd_en,
  input  logic                     fifo_overflow,
  input  logic                     fifo_underflow,
  output logic [CNT_W-1:0]         occupancy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     err
);

  logic [CNT_W:0]       reserved;
  logic                 room;
  logic                 below_thr;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_grant;
  logic [IDX_W-1:0]     ptr;
  logic                 counted_read;
  logic [WIDTH-1:0]     sel_data;

  // The in-flight write is counted so a grant never targets a slot already promised.
  assign reserved  = {1'b0, occupancy} + {{CNT_W{1'b0}}, fifo_wr_en};
  assign room      = reserved < (CNT_W+1)'(DEPTH);
  assign below_thr = reserved < (CNT_W+1)'(THRESHOLD);
  // fifo_rd_en is deliberately absent here: no combinational path from the consumer.
  assign eligible  = req_valid & {NUM_REQ{room}} & ({NUM_REQ{below_thr}} | HIPRI_MASK);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready    = grant;
  assign sel_data     = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign counted_read = fifo_rd_en & (occupancy != '0);

  // Output registers, round-robin pointer, shadow occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      occupancy  <= '0;
      grant_id   <= '0;
      ptr        <= '0;
      err        <= 1'b0;
    end else begin
      fifo_wr_en <= any_grant;
      if (any_grant) begin
        fifo_data <= sel_data;
        grant_id  <= grant_idx;
        ptr       <= IDX_W'(wrap_index(int'(grant_idx), 1, NUM_REQ));
      end
      occupancy <= occupancy + CNT_W'(fifo_wr_en) - CNT_W'(counted_read);
      if (fifo_overflow | fifo_underflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule
